// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding control for an in-order pipeline
// (IF, ID, EX, MEM x MEM_STAGES, WB). Tracks in-flight instructions from EX to
// WB, raises load-use stalls, selects EX forwarding sources, bypasses WB data
// into ID, flushes on taken branches and drains the pipe on a halting ecall.
// Optional feature: define HAZ_PERF_CNT_EN to add stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_STAGES = 1,
    parameter int RA_W       = 5,
    parameter int SEL_W      = $clog2(MEM_STAGES + 3)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_halt,
    input  logic             ex_branch_taken,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic [SEL_W-1:0] fwd_rs1_sel,
    output logic [SEL_W-1:0] fwd_rs2_sel,
    output logic             id_bypass_rs1,
    output logic             id_bypass_rs2,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flushes,
`endif
    output logic             is_halted
);

    // Slot 0 is EX, slot N-1 is WB.
    localparam int N = MEM_STAGES + 2;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic            halt;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    slot_t  r_slot [N];
    state_t r_state;
    state_t w_state_next;
    logic   r_is_halted;
    logic   w_load_use;
    logic   w_flush;
    logic   w_accept;
    slot_t  w_id_entry;

    // A slot produces register r when it will write a non-zero rd equal to r.
    function automatic logic f_produces(input slot_t s, input logic [RA_W-1:0] r);
        return s.valid && s.reg_write && (s.rd == r) && (s.rd != '0);
    endfunction

    // Load-use hazard: ID reads a register that a load still in EX..MEM_STAGES-1 writes.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first; a path that skips the assignment would infer a latch.
        w_load_use = 1'b0;
        for (int k = 0; k < MEM_STAGES; k++) begin
            if (r_slot[k].mem_read &&
                ((id_use_rs1 && f_produces(r_slot[k], id_rs1)) ||
                 (id_use_rs2 && f_produces(r_slot[k], id_rs2)))) begin
                w_load_use = 1'b1;
            end
        end
        w_load_use = w_load_use && id_valid;
    end

    assign w_flush  = ex_branch_taken && r_slot[0].valid;
    assign w_accept = id_valid && !w_load_use && !w_flush && (r_state == ST_RUN);

    // Forwarding for the EX operands: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd_rs1_sel = '0;
        fwd_rs2_sel = '0;
        for (int k = N - 1; k >= 1; k--) begin
            if (r_slot[0].valid && r_slot[0].use_rs1 && f_produces(r_slot[k], r_slot[0].rs1)) begin
                fwd_rs1_sel = SEL_W'(k);
            end
            if (r_slot[0].valid && r_slot[0].use_rs2 && f_produces(r_slot[k], r_slot[0].rs2)) begin
                fwd_rs2_sel = SEL_W'(k);
            end
        end
    end

    assign id_bypass_rs1 = id_use_rs1 && f_produces(r_slot[N-1], id_rs1);
    assign id_bypass_rs2 = id_use_rs2 && f_produces(r_slot[N-1], id_rs2);

    // Entry loaded into slot 0: the ID instruction when accepted, otherwise a bubble.
    always_comb begin
        w_id_entry = '0;
        if (w_accept) begin
            w_id_entry.valid     = 1'b1;
            w_id_entry.rd        = id_rd;
            w_id_entry.reg_write = id_reg_write;
            w_id_entry.mem_read  = id_mem_read;
            w_id_entry.halt      = id_halt;
            w_id_entry.rs1       = id_rs1;
            w_id_entry.rs2       = id_rs2;
            w_id_entry.use_rs1   = id_use_rs1;
            w_id_entry.use_rs2   = id_use_rs2;
        end
    end

    // Advance the in-flight slot chain by one stage every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: every slot is cleared on reset; a stale valid bit would raise phantom stalls and forwards.
            for (int k = 0; k < N; k++) begin
                r_slot[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every slot shift from its pre-edge neighbour.
            r_slot[0] <= w_id_entry;
            for (int k = 1; k < N; k++) begin
                r_slot[k] <= r_slot[k-1];
            end
        end
    end

    // FSM state register plus sticky halted flag, set one edge after HALTED is entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_is_halted <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_is_halted <= r_is_halted || (r_state == ST_HALTED);
        end
    end

    // FSM next state and pipeline control outputs; a taken branch overrides the load-use stall.
    always_comb begin
        w_state_next = r_state;
        stall_pc     = w_load_use && !w_flush;
        stall_if_id  = w_load_use && !w_flush;
        flush_if_id  = w_flush;
        bubble_id_ex = w_load_use || w_flush;
        case (r_state)
            ST_RUN: begin
                if (w_accept && id_halt) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                stall_pc     = 1'b1;
                bubble_id_ex = 1'b1;
                if (r_slot[N-1].valid && r_slot[N-1].halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                stall_pc = 1'b1;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign is_halted = r_is_halted;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Count load-use stall cycles and taken-branch flushes; frozen once halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else if (r_state != ST_HALTED) begin
            if (w_load_use && !w_flush) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (w_flush) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flushes      = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a per-cycle vector table on a
// MEM_STAGES=1 instance, plus hand sequences for the MEM_STAGES=2 stall,
// halt drain, branch-killed halt and asynchronous reset mid-drain.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2, id_reg_write, id_mem_read, id_halt;
    logic       ex_branch_taken;

    logic       stall_pc, stall_if_id, flush_if_id, bubble_id_ex;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
    logic       id_bypass_rs1, id_bypass_rs2, is_halted;

    logic       m2_stall_pc, m2_stall_if_id, m2_flush, m2_bubble;
    logic [2:0] m2_f1, m2_f2;
    logic       m2_byp1, m2_byp2, m2_halted;

    pipe_hazard_ctrl #(.MEM_STAGES(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .id_bypass_rs1(id_bypass_rs1), .id_bypass_rs2(id_bypass_rs2), .is_halted(is_halted)
    );

    pipe_hazard_ctrl #(.MEM_STAGES(2)) dut_m2 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
        .stall_pc(m2_stall_pc), .stall_if_id(m2_stall_if_id), .flush_if_id(m2_flush),
        .bubble_id_ex(m2_bubble), .fwd_rs1_sel(m2_f1), .fwd_rs2_sel(m2_f2),
        .id_bypass_rs1(m2_byp1), .id_bypass_rs2(m2_byp2), .is_halted(m2_halted)
    );

    logic [10:0] out1;
    logic [8:0]  out2;
    assign out1 = {stall_pc, stall_if_id, flush_if_id, bubble_id_ex, fwd_rs1_sel, fwd_rs2_sel,
                   id_bypass_rs1, id_bypass_rs2, is_halted};
    assign out2 = {m2_stall_pc, m2_stall_if_id, m2_bubble, m2_f1, m2_f2};

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, rw, mr, br;
        logic [10:0] exp;
    } vec_t;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected dut output bundle in out1 bit order.
    function automatic logic [10:0] e(input int spc, input int sif, input int fl, input int bb,
                                      input int f1, input int f2, input int b1, input int b2,
                                      input int hl);
        return {1'(spc), 1'(sif), 1'(fl), 1'(bb), 2'(f1), 2'(f2), 1'(b1), 1'(b2), 1'(hl)};
    endfunction

    function automatic vec_t mk(input int v, input int rs1, input int u1, input int rs2,
                                input int u2, input int rd, input int rw, input int mr,
                                input int br, input logic [10:0] exp);
        vec_t t;
        t.v = 1'(v);   t.rs1 = 5'(rs1); t.u1 = 1'(u1); t.rs2 = 5'(rs2); t.u2 = 1'(u2);
        t.rd = 5'(rd); t.rw = 1'(rw);   t.mr = 1'(mr); t.br = 1'(br);   t.exp = exp;
        return t;
    endfunction

    task automatic drive(input vec_t t, input logic ht);
        id_valid = t.v;  id_rs1 = t.rs1; id_use_rs1 = t.u1; id_rs2 = t.rs2; id_use_rs2 = t.u2;
        id_rd = t.rd;    id_reg_write = t.rw; id_mem_read = t.mr; id_halt = ht;
        ex_branch_taken = t.br;
    endtask

    // One pipeline cycle: inputs change after the falling edge, outputs sampled 2 ns later.
    task automatic cyc(input vec_t t, input logic ht);
        @(negedge clk);
        drive(t, ht);
        #2;
    endtask

    vec_t idle_v;
    vec_t tbl [30];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1, 5, 1, 6, 1, 7, 1, 1, 1, '0), 1'b1);
        #2;
        check("reset_outputs_m1", 32'(out1), 32'd0);
        check("reset_outputs_m2", 32'(out2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(idle_v, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        reset  = 1'b1;
        drive(idle_v, 1'b0);

        // Each row: ID inputs for one cycle and the outputs expected in that cycle.
        tbl[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // add x5
        tbl[1]  = mk(1, 5, 1, 1, 1, 6, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // sub x6,x5,x1
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));  // sub in EX: rs1 from slot1
        tbl[3]  = mk(1, 5, 1, 6, 1, 8, 1, 0, 0, e(0,0,0,0,0,0,1,0,0));  // add x5 in WB: bypass rs1
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,2,0,0,0));  // x6 from WB slot
        tbl[5]  = mk(1, 1, 1, 0, 0, 5, 1, 1, 0, e(0,0,0,0,0,0,0,0,0));  // lw x5
        tbl[6]  = mk(1, 5, 1, 5, 1, 7, 1, 0, 0, e(1,1,0,1,0,0,0,0,0));  // add x7,x5,x5: stall
        tbl[7]  = mk(1, 5, 1, 5, 1, 7, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // stall released
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,2,2,0,0,0));  // both from WB
        tbl[9]  = mk(1, 2, 1, 0, 0, 9, 1, 1, 0, e(0,0,0,0,0,0,0,0,0));  // lw x9
        tbl[10] = mk(1, 9, 1, 0, 0,10, 1, 0, 1, e(0,0,1,1,0,0,0,0,0));  // branch beats stall
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, e(0,0,0,0,0,0,0,0,0));  // EX bubble: no flush
        tbl[12] = mk(1, 3, 1, 0, 0, 0, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // write x0
        tbl[13] = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // write x0, read x0
        tbl[14] = mk(1, 0, 1, 0, 1,11, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // x0 never forwarded
        tbl[15] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));  // x0 in slots 1,2
        tbl[16] = mk(1, 1, 1, 0, 0, 9, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // add x9
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        tbl[19] = mk(1, 9, 1, 9, 0,12, 1, 0, 0, e(0,0,0,0,0,0,1,0,0));  // x9 in WB: bypass rs1 only
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));
        tbl[21] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // write x5 (A)
        tbl[22] = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // write x5 (B)
        tbl[23] = mk(1, 5, 1, 5, 0,13, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // read x5, rs2 unused
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,1,0,0,0,0));  // youngest producer wins
        tbl[25] = mk(1, 1, 1, 0, 0, 0, 1, 1, 0, e(0,0,0,0,0,0,0,0,0));  // lw x0
        tbl[26] = mk(1, 0, 1, 0, 1,14, 1, 0, 0, e(0,0,0,0,0,0,0,0,0));  // no stall on x0
        tbl[27] = mk(1, 2, 1, 0, 0, 6, 1, 1, 0, e(0,0,0,0,0,0,0,0,0));  // lw x6
        tbl[28] = mk(1, 3, 1, 6, 1,15, 1, 0, 0, e(1,1,0,1,0,0,0,0,0));  // stall via rs2
        tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, e(0,0,0,0,0,0,0,0,0));

        do_reset();
        for (int i = 0; i < 30; i++) begin
            cyc(tbl[i], 1'b0);
            check($sformatf("vec%0d", i), 32'(out1), 32'(tbl[i].exp));
        end

        // MEM_STAGES=2: lw x5 then add x7,x5,x5 -> two stall cycles, then both selects = 3.
        do_reset();
        cyc(mk(1, 1, 1, 0, 0, 5, 1, 1, 0, '0), 1'b0);
        check("m2_lw_issue", 32'(out2), 32'd0);
        cyc(mk(1, 5, 1, 5, 1, 7, 1, 0, 0, '0), 1'b0);
        check("m2_stall_cycle1", 32'(out2), 32'({1'b1, 1'b1, 1'b1, 3'd0, 3'd0}));
        cyc(mk(1, 5, 1, 5, 1, 7, 1, 0, 0, '0), 1'b0);
        check("m2_stall_cycle2", 32'(out2), 32'({1'b1, 1'b1, 1'b1, 3'd0, 3'd0}));
        cyc(mk(1, 5, 1, 5, 1, 7, 1, 0, 0, '0), 1'b0);
        check("m2_stall_released", 32'(out2), 32'd0);
        cyc(idle_v, 1'b0);
        check("m2_fwd_from_wb", 32'(out2), 32'({1'b0, 1'b0, 1'b0, 3'd3, 3'd3}));

        // Halt drain with N=3: halt accepted at edge t, is_halted from edge t+4.
        do_reset();
        cyc(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, '0), 1'b0);
        check("halt_pre_add", 32'(stall_pc), 32'd0);
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0), 1'b1);
        check("halt_accept_cycle", 32'(stall_pc), 32'd0);
        cyc(idle_v, 1'b0);
        check("drain_t0", 32'({stall_pc, bubble_id_ex, is_halted}), 32'b110);
        cyc(mk(1, 5, 1, 0, 0, 8, 1, 0, 0, '0), 1'b0);
        check("drain_t1_retire_bypass", 32'({stall_pc, bubble_id_ex, id_bypass_rs1, is_halted}), 32'b1110);
        cyc(idle_v, 1'b0);
        check("drain_t2", 32'({stall_pc, bubble_id_ex, is_halted}), 32'b110);
        cyc(idle_v, 1'b0);
        check("halted_t3_not_yet", 32'({stall_pc, is_halted}), 32'b10);
        for (int i = 0; i < 3; i++) begin
            cyc(mk(1, 1, 1, 2, 1, 3, 1, 0, 1, '0), 1'b0);
            check($sformatf("halted_sticky%0d", i), 32'({stall_pc, is_halted}), 32'b11);
        end

        // A taken branch kills the ecall in ID: no drain, no halt.
        do_reset();
        cyc(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, '0), 1'b0);
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, '0), 1'b1);
        check("kill_halt_flush", 32'({stall_pc, flush_if_id, bubble_id_ex}), 32'b011);
        for (int i = 0; i < 6; i++) begin
            cyc(idle_v, 1'b0);
            check($sformatf("kill_halt_run%0d", i), 32'({stall_pc, bubble_id_ex, is_halted}), 32'd0);
        end

        // Asynchronous reset in the middle of DRAIN, then normal operation.
        do_reset();
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, '0), 1'b1);
        cyc(idle_v, 1'b0);
        check("drain_before_async_reset", 32'(stall_pc), 32'd1);
        #1 reset = 1'b1;
        #1 check("async_reset_outputs", 32'(out1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, '0), 1'b0);
        cyc(mk(1, 5, 1, 1, 1, 6, 1, 0, 0, '0), 1'b0);
        check("resume_accepts", 32'(stall_pc), 32'd0);
        cyc(idle_v, 1'b0);
        check("resume_fwd", 32'(out1), 32'(e(0,0,0,0,1,0,0,0,0)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
